// File: rtl/deb_pkg.sv
// Shared state encoding for the push-button debouncer. Each state code carries its
// own outputs in the top four bits: {DPB, SCEN, MCEN, CCEN, tag[1:0]}.
package deb_pkg;

  localparam int unsigned BitDpb  = 5;
  localparam int unsigned BitScen = 4;
  localparam int unsigned BitMcen = 3;
  localparam int unsigned BitCcen = 2;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned RcntW      = 4;

  typedef enum logic [5:0] {
    StIdle    = 6'b0000_00,
    StArm     = 6'b0000_01,
    StScenP   = 6'b1111_00,
    StHold    = 6'b1000_00,
    StMcenP   = 6'b1011_00,
    StRept    = 6'b1001_00,
    StCont    = 6'b1011_01,
    StRelClr  = 6'b1000_01,
    StRelWait = 6'b1000_10
  } state_t;

endpackage

// File: rtl/pb_debounce_ch.sv
// One debouncer channel: press/release filtering, single pulse, auto-repeat pulses and
// continuous mode. Outputs come straight from state register bits.
module pb_debounce_ch
  import deb_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 8,
  parameter int unsigned HOLD_CYC = 64,
  parameter int unsigned MCEN_MAX = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen
);

  localparam int unsigned CntW = $clog2(HOLD_CYC) + 1;
  localparam logic [CntW-1:0]  DebLast  = CntW'(DEB_CYC - 1);
  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYC - 1);
  localparam logic [RcntW-1:0] RcntMax  = RcntW'(MCEN_MAX);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [RcntW-1:0] RcntOne  = RcntW'(1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RcntW-1:0]  rcnt_q, rcnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        rcnt_d = '0;
        if (pb) state_d = StArm;
      end
      StArm: begin
        cnt_d = cnt_q + CntOne;
        if (!pb)                  state_d = StIdle;
        else if (cnt_q == DebLast) state_d = StScenP;
      end
      StScenP: begin
        cnt_d   = '0;
        rcnt_d  = rcnt_q + RcntOne;
        state_d = StHold;
      end
      StHold: begin
        cnt_d = cnt_q + CntOne;
        if (!pb)                    state_d = StRelClr;
        else if (cnt_q == HoldLast) state_d = StMcenP;
      end
      StMcenP: begin
        cnt_d   = '0;
        rcnt_d  = rcnt_q + RcntOne;
        state_d = StRept;
      end
      StRept: begin
        cnt_d = cnt_q + CntOne;
        if (!pb)                    state_d = StRelClr;
        else if (cnt_q == HoldLast) state_d = (rcnt_q == RcntMax) ? StCont : StMcenP;
      end
      StCont: begin
        if (!pb) state_d = StRelClr;
      end
      StRelClr: begin
        cnt_d   = '0;
        rcnt_d  = '0;
        state_d = StRelWait;
      end
      StRelWait: begin
        cnt_d = cnt_q + CntOne;
        // A bounce restarts the hold timer from zero without a fresh SCEN.
        if (pb) begin
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        rcnt_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign dpb  = state_q[BitDpb];
  assign scen = state_q[BitScen];
  assign mcen = state_q[BitMcen];
  assign ccen = state_q[BitCcen];

endmodule

// File: rtl/multi_pb_debouncer.sv
// N-channel push-button debouncer with registered ANY_DPB. Define DEB_SYNC_EN to add a
// 2-flop synchroniser on every PB bit (adds two cycles of latency).
module multi_pb_debouncer
  import deb_pkg::*;
#(
  parameter int unsigned N_CH     = 5,
  parameter int unsigned DEB_CYC  = 8,
  parameter int unsigned HOLD_CYC = 64,
  parameter int unsigned MCEN_MAX = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] DPB,
  output logic [N_CH-1:0] SCEN,
  output logic [N_CH-1:0] MCEN,
  output logic [N_CH-1:0] CCEN,
  output logic            ANY_DPB
);

  logic [N_CH-1:0] pb_s;
  logic            any_dpb_q;

`ifdef DEB_SYNC_EN
  logic [SyncStages-1:0][N_CH-1:0] sync_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[SyncStages-2:0], PB};
  end

  assign pb_s = sync_q[SyncStages-1];
`else
  assign pb_s = PB;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_debounce_ch #(
      .DEB_CYC  (DEB_CYC),
      .HOLD_CYC (HOLD_CYC),
      .MCEN_MAX (MCEN_MAX)
    ) u_ch (
      .CLK   (CLK),
      .RESET (RESET),
      .pb    (pb_s[i]),
      .dpb   (DPB[i]),
      .scen  (SCEN[i]),
      .mcen  (MCEN[i]),
      .ccen  (CCEN[i])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) any_dpb_q <= 1'b0;
    else       any_dpb_q <= |DPB;
  end

  assign ANY_DPB = any_dpb_q;

endmodule
